shift_reg_deser: RTL

Sequential serial-to-parallel collector, the receive-side counterpart of the shift/rotate datapath. It captures a serial bit stream one bit per qualified cycle and assembles WIDTH-bit words. Bits enter at the LSB (shift left) or the MSB (shift right), matching the shift-mode insertion rules. Completed words are presented on a valid/ready output buffer, so collection of the next word continues while the previous word waits.

---
 rtl/shift_reg_deser.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/shift_reg_deser.sv
// shift_reg_deser: serial-to-parallel collector with a one-word valid/ready
// output buffer.
//
// Bits are accepted on bit_valid and shifted into a WIDTH-bit collector. The
// insertion side is chosen by the direction input on the first bit of each
// word and then held for the rest of that word:
//   direction=1 : insert at LSB (shift left), stream is MSB-first
//   direction=0 : insert at MSB (shift right), stream is LSB-first
//
// Optional build macro PARITY_CHECK_EN: each word is followed by one extra
// even-parity bit. The word is delivered on the parity-bit edge, and the
// parity_err output reports (^word ^ parity_bit).
//
// dbg_state exposes the collector FSM state for checkers.

module shift_reg_deser #(
  parameter int WIDTH = 6,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             direction,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic [1:0]       dbg_state
);

  // Output handshake: word_out/word_valid form a valid/ready source. A word
  // is transferred on a rising edge where word_valid=1 and word_ready=1.
  // word_valid never drops without such a transfer (or clear/reset), and
  // word_out is stable while word_valid=1 and word_ready=0. word_ready is
  // ignored while word_valid=0.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             dir_q,   dir_d;

  logic [WIDTH-1:0] word_q,  word_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;

  // Completion strobe and the word it carries (Mealy outputs of the collector).
  logic             done;
  logic [WIDTH-1:0] done_word;
  logic [WIDTH-1:0] shifted;

`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
  logic             done_perr;
`endif

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Insert one bit at the LSB (left) or MSB (right) end of the collector.
  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] cur,
    input logic             b,
    input logic             left
  );
    if (left) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  // Collector state register: FSM state, shift register, count, latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Collector next-state logic: shifting, counting and word boundaries.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (clear) begin
      state_d = S_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (bit_valid) begin
      case (state_q)
        S_IDLE: begin
          // First bit of a word: the direction is sampled here only.
          dir_d   = direction;
          shreg_d = shift_in(shreg_q, serial_in, direction);
          cnt_d   = CW'(1);
          state_d = S_COLLECT;
        end
        S_COLLECT: begin
          shreg_d = shift_in(shreg_q, serial_in, dir_q);
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
`ifdef PARITY_CHECK_EN
            state_d = S_PARITY;
`else
            state_d = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        S_PARITY: begin
          // The parity bit is consumed but never shifted into the word.
          state_d = S_IDLE;
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Collector outputs: completion strobe, completed word and debug state.
  always_comb begin
    shifted   = shift_in(shreg_q, serial_in, dir_q);
    done      = 1'b0;
    done_word = shifted;
`ifdef PARITY_CHECK_EN
    done_perr = ^shreg_q ^ serial_in;
    if (!clear && bit_valid && state_q == S_PARITY) begin
      done      = 1'b1;
      done_word = shreg_q;
    end
`else
    if (!clear && bit_valid && state_q == S_COLLECT && cnt_q == LAST_CNT) begin
      done = 1'b1;
    end
`endif
    dbg_state = state_q;
  end

  // Output buffer next-state: load, hand off, drop-with-overrun, flush.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef PARITY_CHECK_EN
    perr_d  = perr_q;
`endif
    if (clear) begin
      // word_out deliberately keeps its last value across a flush.
      valid_d = 1'b0;
      ovr_d   = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_d  = 1'b0;
`endif
    end else if (done) begin
      if (!valid_q || word_ready) begin
        // Empty, or the pending word leaves on this same edge: no bubble.
        word_d  = done_word;
        valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_d  = done_perr;
`endif
      end else begin
        // Buffer full and not draining: the new word is lost.
        ovr_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_d  = 1'b0;
`endif
    end
  end

  // Output buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`endif

endmodule
